// File: rtl/hc652_pipe.sv
// Purpose : registered bus transceiver in the 74HC652 style, DEPTH capture stages per direction.
// Latency : live path 0 cycles; stored path exactly DEPTH enabled clock edges from input to output.
// Backpres: none; capture advances only on cpen_ab/cpen_ba, otherwise every stage holds.
//
// Ports:
//    clk, rst_n         shared rising-edge clock (CPAB/CPBA), async active-low reset
//    a_in, b_in         bus inputs, A side and B side
//    b_out, a_out       tri-state bus drives (A->B onto B side, B->A onto A side)
//    oeab, oeba_n       output enables (A->B active-high, B->A active-low)
//    sab, sba           source select: 0 = live input, 1 = stored (last pipeline stage)
//    cpen_ab, cpen_ba   capture enables for each pipeline
//    ab_ready, ba_ready high once the pipeline has taken DEPTH captures since reset

// One direction: DEPTH-stage capture shift register plus saturating fill counter.
module hc652_lane #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cpen,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] stored,
   output logic             ready
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   logic [WIDTH-1:0] stage [DEPTH];
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else if (cpen) begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   // Counter saturates at DEPTH; ready is set on the same edge as the
   // DEPTH-th capture so it lines up with the first valid stored word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         ready <= 1'b0;
      end else if (cpen) begin
         if (cnt != FULL) begin
            cnt <= cnt + CW'(1);
         end
         if (cnt >= LAST) begin
            ready <= 1'b1;
         end
      end
   end

   assign stored = stage[DEPTH-1];

endmodule

module hc652_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] b_out,
   output logic [WIDTH-1:0] a_out,
   input  logic             oeab,
   input  logic             oeba_n,
   input  logic             sab,
   input  logic             sba,
   input  logic             cpen_ab,
   input  logic             cpen_ba,
   output logic             ab_ready,
   output logic             ba_ready
);

   logic [WIDTH-1:0] ab_stored;
   logic [WIDTH-1:0] ba_stored;

   hc652_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ab (
      .clk    (clk),
      .rst_n  (rst_n),
      .cpen   (cpen_ab),
      .din    (a_in),
      .stored (ab_stored),
      .ready  (ab_ready)
   );

   hc652_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ba (
      .clk    (clk),
      .rst_n  (rst_n),
      .cpen   (cpen_ba),
      .din    (b_in),
      .stored (ba_stored),
      .ready  (ba_ready)
   );

   // Output muxes are purely combinational, so the stored path reads 0 as
   // soon as reset clears the stages, with no clock required.
   assign b_out = oeab    ? (sab ? ab_stored : a_in) : {WIDTH{1'bz}};
   assign a_out = !oeba_n ? (sba ? ba_stored : b_in) : {WIDTH{1'bz}};

endmodule

// File: doc/hc652_pipe.md
Name: hc652_pipe

Overview:
- Parametrised successor to the octal bus transceiver model: a registered bus transceiver/register in the 74HC652 style.
- Each direction (A->B, B->A) has a DEPTH-stage capture pipeline, a live/stored output-source select and tri-state output drivers.
- Used where board-level models need latched or delayed bus transfer at any width.
- Input and output buses are separate ports, as in the edited unidirectional transceiver model.

Parameters:
- WIDTH, 8, bus width in bits (1..32).
- DEPTH, 1, register stages per direction (1..4); DEPTH=1 is the classic 652.

Ports:
- clk  in  1  single rising-edge clock; shared CPAB/CPBA.
- rst_n  in  1  asynchronous active-low reset.
- a_in  in  WIDTH  A-side bus input.
- b_in  in  WIDTH  B-side bus input.
- b_out  out  WIDTH  B-side drive, A->B direction; tri-state.
- a_out  out  WIDTH  A-side drive, B->A direction; tri-state.
- oeab  in  1  A->B output enable, active-high.
- oeba_n  in  1  B->A output enable, active-low.
- sab  in  1  0 = b_out shows live a_in; 1 = b_out shows stored A data.
- sba  in  1  0 = a_out shows live b_in; 1 = a_out shows stored B data.
- cpen_ab  in  1  capture enable, A->B pipeline.
- cpen_ba  in  1  capture enable, B->A pipeline.
- ab_ready  out  1  A->B pipeline fully primed since reset.
- ba_ready  out  1  B->A pipeline fully primed since reset.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed):
  - All pipeline stages cleared to 0.
  - Occupancy counters cleared to 0.
  - ab_ready=0, ba_ready=0.
  - b_out/a_out still follow their enable/select logic; stored-path value reads 0.
- Release of reset: synchronous in effect; the first capture occurs on the first rising clk edge with rst_n=1.
- A->B pipeline: stages ab[0..DEPTH-1].
  - On a rising clk edge with cpen_ab=1: ab[0]<=a_in and ab[i]<=ab[i-1].
  - With cpen_ab=0 all stages hold.
  - Capture is independent of oeab and sab.
- B->A pipeline: identical structure, using b_in, ba[], cpen_ba.
- Stored value is the last stage: ab[DEPTH-1] (resp. ba[DEPTH-1]).
  - Latency a_in -> stored: exactly DEPTH enabled clock edges.
- Output logic (combinational):
  - b_out = oeab ? (sab ? ab[DEPTH-1] : a_in) : all-Z.
  - a_out = ~oeba_n ? (sba ? ba[DEPTH-1] : b_in) : all-Z.
  - The live path has zero latency.
- Occupancy counter per direction:
  - Width ceil(log2(DEPTH+1)).
  - Increments on each enabled capture; saturates at DEPTH and never wraps.
  - ready = (count==DEPTH), registered; it rises on the same edge as the DEPTH-th capture.
  - Ready stays high until reset.
- Both directions may be enabled simultaneously and capture on the same edge. There is no contention because input and output ports are separate.
- Output-enable or select changes mid-pipeline do not disturb stored data.
- Reset asserted mid-operation clears all state immediately. Outputs on the stored path read 0 in the same delta.
- X or Z on oeab/oeba_n is not defined; the bench never drives it.

Test Plan:
- Reset, then oeab=1, sab=1, DEPTH=1 -> b_out=0x00, ab_ready=0. One edge with cpen_ab=1, a_in=0xA5 -> b_out=0xA5, ab_ready=1.
- DEPTH=3, cpen_ab=1, a_in=0x11,0x22,0x33 on successive edges:
  - After edge 2: b_out(sab=1)=0x00, ab_ready=0.
  - After edge 3: b_out=0x11, ab_ready=1.
- sab=0, oeab=1, a_in toggled 0x3C->0xC3 with no clock -> b_out follows immediately. Then oeab=0 -> b_out=Z on all WIDTH bits.
- cpen_ba=0 for 5 edges with b_in changing -> stored B->A value unchanged. With oeba_n=0, sba=1 -> a_out holds the prior capture, 0x5A.
- Both directions with cpen both 1, a_in=0x0F, b_in=0xF0, one edge, sab=sba=1, both enabled -> b_out=0x0F, a_out=0xF0.
- WIDTH=16, DEPTH=2, pipeline primed (ab_ready=1), rst_n pulsed low between edges -> b_out(sab=1)=0x0000 and ab_ready=0 immediately, without waiting for clk.
